// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam bit MSB_FIRST = 1'b1;
    localparam bit LSB_FIRST = 1'b0;

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Frame bit counter: clears on frame start, counts shifted bits, flags the last one.
module bit_counter #(
    parameter int n = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(n)-1:0] cnt,
    output logic                 last
);

    localparam int unsigned CW = $clog2(n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(n - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer for gap-free frames.
module piso_tx #(
    parameter int n         = piso_pkg::DEFAULT_WIDTH,
    parameter bit MSB_FIRST = piso_pkg::MSB_FIRST
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] pi,
    output logic         ready,
    output logic         so,
    output logic         so_valid,
    output logic         sof,
    output logic         eof,
    output logic         busy
);

    import piso_pkg::*;

    localparam int unsigned CW = $clog2(n);

    state_t          state;
    logic [n-1:0]    hold;
    logic            hold_full;
    logic [n-1:0]    sr;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            accept;
    logic            transfer;
    logic            in_shift;
    logic            cnt_clr;
    logic            cnt_inc;

    assign in_shift = (state == SHIFT);
    assign accept   = load && !hold_full;
    // Transfer only ever happens with hold full, accept only with hold empty: never both.
    assign transfer = hold_full && (!in_shift || last);
    assign cnt_clr  = transfer || (in_shift && last);
    assign cnt_inc  = in_shift && !last;

    bit_counter #(
        .n(n)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sr        <= '0;
        end else begin
            if (accept) begin
                hold <= pi;
            end
            if (transfer) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        sr    <= hold;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        if (hold_full) begin
                            sr <= hold;
                        end else begin
                            sr    <= '0;
                            state <= IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        sr <= {sr[n-2:0], 1'b0};
                    end else begin
                        sr <= {1'b0, sr[n-1:1]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready    = !hold_full;
    assign so       = in_shift && (MSB_FIRST ? sr[n-1] : sr[0]);
    assign so_valid = in_shift;
    assign sof      = in_shift && (cnt == '0);
    assign eof      = in_shift && last;
    assign busy     = in_shift || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one MSB-first and one LSB-first instance, 8-bit words.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       load_m = 1'b0;
    logic [7:0] pi_m = '0;
    logic       ready_m, so_m, so_valid_m, sof_m, eof_m, busy_m;

    logic       load_l = 1'b0;
    logic [7:0] pi_l = '0;
    logic       ready_l, so_l, so_valid_l, sof_l, eof_l, busy_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    piso_tx #(.n(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load(load_m), .pi(pi_m),
        .ready(ready_m), .so(so_m), .so_valid(so_valid_m),
        .sof(sof_m), .eof(eof_m), .busy(busy_m)
    );

    piso_tx #(.n(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load(load_l), .pi(pi_l),
        .ready(ready_l), .so(so_l), .so_valid(so_valid_l),
        .sof(sof_l), .eof(eof_l), .busy(busy_l)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        total++;
        if ({so_m, so_valid_m, sof_m, eof_m, busy_m} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000", {so_m, so_valid_m, sof_m, eof_m, busy_m});
        end
        reset = 1'b0;
        cyc();
        total++;
        if (ready_m !== 1'b1 || busy_m !== 1'b0 || ready_l !== 1'b1) begin
            bad++;
            $display("FAIL reset_release ready_m=%b busy_m=%b ready_l=%b exp 1 0 1", ready_m, busy_m, ready_l);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({so_m, so_valid_m, busy_m, ready_m} !== 4'b0001) begin
                bad++;
                $display("FAIL idle cyc=%0d got=%b exp=0001", i, {so_m, so_valid_m, busy_m, ready_m});
            end
            cyc();
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_bits = 8'hC5;
        load_m = 1'b1;
        pi_m = 8'hC5;
        cyc();
        load_m = 1'b0;
        total++;
        if (ready_m !== 1'b0 || so_valid_m !== 1'b0 || busy_m !== 1'b1) begin
            bad++;
            $display("FAIL single_accept ready=%b so_valid=%b busy=%b exp 0 0 1", ready_m, so_valid_m, busy_m);
        end
        cyc();
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({so_valid_m, so_m, sof_m, eof_m} !== {1'b1, exp_bits[7-i], i == 0, i == 7}) begin
                bad++;
                $display("FAIL single_bit i=%0d got=%b exp=%b", i, {so_valid_m, so_m, sof_m, eof_m},
                         {1'b1, exp_bits[7-i], i == 0, i == 7});
            end
            cyc();
        end
        total++;
        if (so_valid_m !== 1'b0 || busy_m !== 1'b0 || ready_m !== 1'b1) begin
            bad++;
            $display("FAIL single_end so_valid=%b busy=%b ready=%b exp 0 0 1", so_valid_m, busy_m, ready_m);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_bits = 8'hC5;
        load_l = 1'b1;
        pi_l = 8'hC5;
        cyc();
        load_l = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({so_valid_l, so_l, sof_l, eof_l} !== {1'b1, exp_bits[i], i == 0, i == 7}) begin
                bad++;
                $display("FAIL lsb_bit i=%0d got=%b exp=%b", i, {so_valid_l, so_l, sof_l, eof_l},
                         {1'b1, exp_bits[i], i == 0, i == 7});
            end
            cyc();
        end
        total++;
        if (so_valid_l !== 1'b0 || busy_l !== 1'b0) begin
            bad++;
            $display("FAIL lsb_end so_valid=%b busy=%b exp 0 0", so_valid_l, busy_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream = 16'hA53C;
        load_m = 1'b1;
        pi_m = 8'hA5;
        cyc();
        load_m = 1'b0;
        cyc();
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                total++;
                if (ready_m !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_return got=%b exp=1", ready_m);
                end
                load_m = 1'b1;
                pi_m = 8'h3C;
            end else if (k == 1) begin
                load_m = 1'b0;
                total++;
                if (ready_m !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_ready_held got=%b exp=0", ready_m);
                end
            end
            total++;
            if ({so_valid_m, so_m, sof_m, eof_m} !== {1'b1, stream[15-k], k == 0 || k == 8, k == 7 || k == 15}) begin
                bad++;
                $display("FAIL b2b_bit k=%0d got=%b exp=%b", k, {so_valid_m, so_m, sof_m, eof_m},
                         {1'b1, stream[15-k], k == 0 || k == 8, k == 7 || k == 15});
            end
            cyc();
        end
        total++;
        if (so_valid_m !== 1'b0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end so_valid=%b busy=%b exp 0 0", so_valid_m, busy_m);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] stream = 24'hC511FF;
        load_m = 1'b1;
        pi_m = 8'hC5;
        cyc();
        load_m = 1'b0;
        cyc();
        load_m = 1'b1;
        pi_m = 8'h11;
        cyc();
        for (int k = 1; k < 24; k++) begin
            if (k >= 1 && k <= 3) begin
                load_m = 1'b1;
                pi_m = 8'hFF;
                total++;
                if (ready_m !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_ready_low k=%0d got=%b exp=0", k, ready_m);
                end
            end else if (k == 8) begin
                total++;
                if (ready_m !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_ready_return got=%b exp=1", ready_m);
                end
                load_m = 1'b1;
                pi_m = 8'hFF;
            end else begin
                load_m = 1'b0;
            end
            total++;
            if ({so_valid_m, so_m, sof_m, eof_m} !==
                {1'b1, stream[23-k], k == 8 || k == 16, k == 7 || k == 15 || k == 23}) begin
                bad++;
                $display("FAIL bp_bit k=%0d got=%b exp=%b", k, {so_valid_m, so_m, sof_m, eof_m},
                         {1'b1, stream[23-k], k == 8 || k == 16, k == 7 || k == 15 || k == 23});
            end
            cyc();
        end
        load_m = 1'b0;
        total++;
        if (so_valid_m !== 1'b0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL bp_end so_valid=%b busy=%b exp 0 0", so_valid_m, busy_m);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_bits = 8'hC5;
        load_m = 1'b1;
        pi_m = 8'hC5;
        cyc();
        load_m = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                load_m = 1'b1;
                pi_m = 8'h3C;
            end else begin
                load_m = 1'b0;
            end
            total++;
            if (so_m !== exp_bits[7-k] || so_valid_m !== 1'b1) begin
                bad++;
                $display("FAIL mid_bit k=%0d got=%b exp=1%b", k, {so_valid_m, so_m}, exp_bits[7-k]);
            end
            cyc();
        end
        reset = 1'b1;
        #1;
        total++;
        if ({so_valid_m, so_m, ready_m, busy_m} !== 4'b0010) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=0010", {so_valid_m, so_m, ready_m, busy_m});
        end
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if ({so_valid_m, so_m, busy_m, ready_m} !== 4'b0001) begin
                bad++;
                $display("FAIL mid_after cyc=%0d got=%b exp=0001", i, {so_valid_m, so_m, busy_m, ready_m});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter that takes n-bit words from the parallel register domain and streams them out one bit per clock, framed by start and end strobes. It is the transmit end of the team's register-to-serial link: words arrive through a load/ready handshake, and the block drives the serial line that a downstream SIPO receiver reassembles. A one-word holding buffer allows gap-free back-to-back frames.

## Interface
- n, default 8, word width in bits (n ≥ 2)
- MSB_FIRST, default 1, bit order on so: 1 sends pi[n-1] first, 0 sends pi[0] first
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  word offered on pi this cycle
- pi  input  n  parallel word to transmit
- ready  output  1  holding buffer empty; a word is accepted when load && ready at a rising edge
- so  output  1  serial data bit
- so_valid  output  1  so carries a frame bit this cycle
- sof  output  1  high with the first bit of each frame
- eof  output  1  high with the last bit of each frame
- busy  output  1  shifter active or holding buffer full

## Operation
- Storage: holding register hold[n-1:0] with flag hold_full; shift register sr[n-1:0]; bit counter cnt of width $clog2(n); state IDLE/SHIFT.
- ready = ~hold_full. The block ignores load while ready is low, and pi is not sampled then.
- Accept: load && ready at an edge → hold <= pi, hold_full <= 1.
- IDLE: if hold_full → sr <= hold, hold_full <= 0, cnt <= 0, go to SHIFT.
- SHIFT: each edge shifts sr one position toward the output end and increments cnt.
- SHIFT, cnt == n-1 (last bit): if hold_full → reload sr from hold, cnt <= 0, stay in SHIFT (no idle gap); else go to IDLE.
- so = sr[n-1] (MSB_FIRST) or sr[0] (LSB first) while in SHIFT; 0 in IDLE.
- so_valid = (state == SHIFT); sof = SHIFT && cnt == 0; eof = SHIFT && cnt == n-1.
- busy = (state == SHIFT) || hold_full.
- Accept and transfer in the same edge cannot conflict: accept needs hold empty, and transfer needs hold full.

## Timing
- Reset (asynchronous): state = IDLE, hold_full = 0, sr = 0, cnt = 0.
- Output values during and after reset: so = 0, so_valid = 0, sof = 0, eof = 0, busy = 0, ready = 1 once reset is released.
- Latency: a word accepted at edge E0 transfers at E1. Its first bit (sof = 1) is on so in the cycle after E1, and its last bit (eof = 1) is n-1 cycles later.
- ready drops in the cycle after an accept and rises in the cycle after the hold-to-sr transfer.
- Throughput: one word per n cycles sustained. Back-to-back frames give a continuous so_valid with eof of frame k immediately followed by sof of frame k+1.
- Reset mid-frame aborts the frame immediately: so_valid and so go to 0 and the held word is discarded.

## Structure
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT)
  - the default width constant (8)
  - the bit-order constants (MSB_FIRST = 1, LSB_FIRST = 0)
- The counter is a natural sub-module: bit_counter, parameterised by n, with inputs clr and inc and outputs cnt and last (cnt == n-1).
- Everything else stays in piso_tx.

## Test plan
- Reset then single word: n = 8, MSB_FIRST = 1, load 8'hC5 for one cycle → so = 1,1,0,0,0,1,0,1 on 8 consecutive so_valid cycles starting 2 cycles after accept. sof on bit 1, eof on bit 8, then so_valid = 0 and busy = 0.
- Bit order: MSB_FIRST = 0, load 8'hC5 → so = 1,0,1,0,0,0,1,1.
- Back-to-back: load 8'hA5 and then, as soon as ready returns, 8'h3C → 16 consecutive so_valid cycles carrying 10100101 then 00111100. eof on cycle 8 and sof on cycle 9, no gap.
- Backpressure: with hold full, drive load = 1 and pi = 8'hFF for 3 cycles → ready = 0 throughout. The value 8'hFF is never transmitted until ready returns and it is accepted once.
- Reset mid-frame: assert reset after bit 4 of 8'hC5 with a second word held → so_valid = 0 and ready = 1 immediately. After release, no bits are sent until a new load.
- Idle hold: no load for 20 cycles after reset → so = 0, so_valid = 0, busy = 0, ready = 1 throughout.
